// File: rtl/mod_exp_pkg.sv
// Shared types, default widths and latency helper for the modular-exponentiation engine.
package mod_exp_pkg;

  localparam int unsigned DefaultWidth    = 16;
  localparam int unsigned DefaultExpWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StFinish,
    StError
  } mod_exp_state_t;

  // Cycles from the accepted start to the done pulse: one launch cycle, then per exponent bit
  // one launch, WIDTH shift-add iterations and one writeback.
  function automatic int unsigned MODEXP_LATENCY(input int unsigned w, input int unsigned e);
    return 1 + e * (w + 2);
  endfunction

endpackage

// File: rtl/mod_mult.sv
// MSB-first interleaved shift-add modular multiplier: p = a*b mod n, fixed WIDTH+1 cycle latency.
// Requires a, b < n so that the running sum 2P+B stays below 3n and fits WIDTH+2 bits.
module mod_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned AccW = WIDTH + 2;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, n_q, p_q, p_next;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;
  logic [AccW-1:0]  p_sum, p_red, n_ext;

  // One iteration: P = 2P + a_i*B, then at most two conditional subtractions of n.
  always_comb begin
    n_ext  = {2'b00, n_q};
    p_sum  = {1'b0, p_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : {AccW{1'b0}});
    p_red  = (p_sum >= n_ext) ? p_sum - n_ext : p_sum;
    p_next = (p_red >= n_ext) ? WIDTH'(p_red - n_ext) : WIDTH'(p_red);
  end

  // Operand load on start, then WIDTH iterations; done pulses the cycle after the last one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        p_q   <= '0;
        cnt_q <= CntW'(WIDTH);
      end else if (cnt_q != '0) begin
        p_q   <= p_next;
        a_q   <= a_q << 1;
        cnt_q <= cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign p    = p_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Constant-time right-to-left square-and-multiply modular exponentiation coprocessor.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned EXP_WIDTH = DefaultExpWidth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  localparam int unsigned CntW = $clog2(EXP_WIDTH + 1);

  mod_exp_state_t       state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d, sq_q, sq_d, n_q, n_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 mult_start, a_done, b_done;
  logic [WIDTH-1:0]     a_p, b_p;

  // A: acc*sq, always computed so latency does not depend on the exponent bits.
  mod_mult #(.WIDTH(WIDTH)) u_mult_a (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (acc_q),
    .b     (sq_q),
    .n     (n_q),
    .done  (a_done),
    .p     (a_p)
  );

  // B: sq*sq.
  mod_mult #(.WIDTH(WIDTH)) u_mult_b (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (sq_q),
    .b     (sq_q),
    .n     (n_q),
    .done  (b_done),
    .p     (b_p)
  );

  // Next-state, datapath updates and multiplier launch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sq_d       = sq_q;
    n_d        = n_q;
    exp_d      = exp_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    err_d      = err_q;
    mult_start = 1'b0;
    case (state_q)
      // FINISH and ERROR accept a new request too, so start in the done cycle is not lost.
      StIdle, StFinish, StError: begin
        state_d = StIdle;
        if (start) begin
          n_d   = modulus;
          exp_d = exponent;
          acc_d = WIDTH'(1);
          sq_d  = base;
          cnt_d = CntW'(EXP_WIDTH);
          if ((modulus < WIDTH'(2)) || (base >= modulus)) begin
            state_d  = StError;
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        mult_start = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (a_done && b_done) begin
          if (exp_q[0]) acc_d = a_p;
          sq_d  = b_p;
          exp_d = exp_q >> 1;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_d  = StFinish;
            result_d = acc_d;
            err_d    = 1'b0;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      sq_q     <= '0;
      n_q      <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sq_q     <= sq_d;
      n_q      <= n_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == StLaunch) || (state_q == StWait);
  assign done   = (state_q == StFinish) || (state_q == StError);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench: directed literal cases plus randomized requests against a cycle-level
// reference of the request/response protocol and an arithmetic modexp model.
module tb_mod_exp_engine;
  import mod_exp_pkg::*;

  localparam int unsigned W   = DefaultWidth;
  localparam int unsigned E   = DefaultExpWidth;
  localparam int          LAT = int'(MODEXP_LATENCY(W, E));

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [E-1:0] exponent = '0;
  logic [W-1:0] modulus = '0;
  logic         busy, done, err;
  logic [W-1:0] result;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
  endtask

  // Plain square-and-multiply on wide integers.
  function automatic logic [W-1:0] ref_modexp(input longint unsigned b, input longint unsigned e,
                                              input longint unsigned n);
    longint unsigned r = 1;
    longint unsigned x = b % n;
    longint unsigned k = e;
    while (k != 0) begin
      if ((k & 1) != 0) r = (r * x) % n;
      x = (x * x) % n;
      k = k >> 1;
    end
    return W'(r % n);
  endfunction

  // Reference protocol model and per-cycle compare.
  initial begin
    bit           pend = 0;
    int           acc_cyc = 0, done_cyc = 0;
    logic [W-1:0] m_res = '0, last_res = '0;
    logic         m_err = 1'b0, last_err = 1'b0;
    logic         exp_busy, exp_done;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_outs", {13'd0, busy, done, err, result}, 32'd0);
        pend     = 0;
        last_res = '0;
        last_err = 1'b0;
      end else begin
        exp_busy = pend && (cyc > acc_cyc) && (cyc < done_cyc);
        exp_done = pend && (cyc == done_cyc);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        if (exp_done) begin
          chk("result", result, m_res);
          chk("err", err, m_err);
          last_res = m_res;
          last_err = m_err;
          pend     = 0;
        end else if (!exp_busy) begin
          chk("held_result", result, last_res);
          chk("held_err", err, last_err);
        end
        if (start && !exp_busy) begin
          pend    = 1;
          acc_cyc = cyc;
          if (modulus < 2 || base >= modulus) begin
            done_cyc = cyc + 1;
            m_res    = '0;
            m_err    = 1'b1;
          end else begin
            done_cyc = cyc + LAT;
            m_res    = ref_modexp(base, exponent, modulus);
            m_err    = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
  endtask

  // Issue one request, scramble inputs afterwards, optionally re-pulse start mid-run.
  task automatic drive_op(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] n,
                          input bit poke, output bit ok, output int lat);
    int t0;
    @(posedge clk); #1;
    base = b; exponent = e; modulus = n; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base = W'($urandom); exponent = E'($urandom); modulus = W'($urandom);
    if (poke) begin
      repeat (50) @(posedge clk);
      #1;
      start = 1'b1;
      base = W'($urandom); exponent = E'($urandom); modulus = W'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(400, ok);
    lat = cyc - t0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] b, input logic [E-1:0] e,
                        input logic [W-1:0] n, input bit poke, input logic [W-1:0] exp_res,
                        input logic exp_err, input int exp_lat);
    bit ok;
    int lat;
    drive_op(b, e, n, poke, ok, lat);
    chk({name, "_timeout"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_result"}, result, exp_res);
      chk({name, "_err"}, err, exp_err);
    end
  endtask

  initial begin
    bit           ok;
    int           t0, lat, ndone;
    logic [W-1:0] rb, rn;
    logic [E-1:0] re;
    int           mode;

    repeat (3) @(posedge clk);
    #1;
    chk("init_state", {13'd0, busy, done, err, result}, 32'd0);
    reset = 1'b1;

    run_op("basic", 16'd4, 16'd13, 16'd497, 0, 16'd445, 1'b0, 289);
    run_op("exp_zero", 16'd2, 16'd0, 16'd1000, 0, 16'd1, 1'b0, 289);
    run_op("base_zero", 16'd0, 16'd5, 16'd7, 0, 16'd0, 1'b0, 289);
    run_op("wide_sq", 16'd65534, 16'd2, 16'd65535, 0, 16'd1, 1'b0, 289);
    run_op("wide_max", 16'd65534, 16'd65535, 16'd65535, 0, 16'd65534, 1'b0, 289);
    run_op("err_mod1", 16'd0, 16'd7, 16'd1, 0, 16'd0, 1'b1, 1);
    run_op("err_base", 16'd500, 16'd3, 16'd497, 0, 16'd0, 1'b1, 1);
    run_op("mid_start", 16'd4, 16'd13, 16'd497, 1, 16'd445, 1'b0, 289);

    // Back-to-back: second request presented in the done cycle of the first.
    @(posedge clk); #1;
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc != t0 + 289) begin
      @(posedge clk); #1;
    end
    base = 16'd3; exponent = 16'd5; modulus = 16'd7; start = 1'b1;
    @(negedge clk);
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    chk("b2b_first_result", result, 32'd445);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = t0 + 289;
    wait_done(400, ok);
    chk("b2b_timeout", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("b2b_latency", cyc - t0, 32'd289);
      chk("b2b_result", result, 32'd5);
    end

    // Reset in the middle of a run.
    @(posedge clk); #1;
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_mid_outs", {13'd0, busy, done, err, result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    ndone = 0;
    repeat (320) begin
      @(negedge clk);
      if (done !== 1'b0) ndone++;
    end
    chk("no_done_after_reset", ndone, 32'd0);
    run_op("post_reset", 16'd4, 16'd13, 16'd497, 0, 16'd445, 1'b0, 289);

    // Randomized requests; per-cycle compare supplies the expectations.
    for (int k = 0; k < 20; k++) begin
      mode = int'($urandom_range(0, 9));
      rn   = W'($urandom_range(2, 65535));
      re   = E'($urandom_range(0, 65535));
      rb   = W'($urandom_range(0, int'(rn) - 1));
      if (mode == 0) begin
        rn = W'($urandom_range(0, 1));
        rb = W'($urandom);
      end else if (mode == 1) begin
        rb = W'($urandom_range(int'(rn), 65535));
      end else if (mode == 2) begin
        re = E'($urandom_range(0, 3));
      end
      drive_op(rb, re, rn, (mode > 1) && ($urandom_range(0, 2) == 0), ok, lat);
      chk("rand_timeout", {31'd0, ok}, 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
